dot_product_feeder: RTL

Front-end sequencer and result collector for the 4-MLP fp16 dot-product stack.
- Accepts a length command, then a stream of (a,b) fp16 element pairs with valid/ready.
- Packs the elements into 8-lane blocks, zero-pads the tail block, and drives the stack's a/b/first/last inputs.
- Captures the stack's sum/valid into a result FIFO.
- Issues a new vector only when result space is guaranteed, because the stack cannot stall.

---
 rtl/dp_pkg.sv | 24 ++
 rtl/dp_result_fifo.sv | 73 +++++++
 rtl/dot_product_feeder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/dp_pkg.sv
// -----------------------------------------------------------------------------
// dp_pkg
// Shared constants and types for the fp16 dot-product feeder.
//   LANES     : elements per block presented to the dot-product stack
//   FP        : element width (fp16)
//   FP16_ZERO : fp16 +0.0, used for padding and idle blocks
//   fp16_t    : one fp16 element
//   state_t   : feeder FSM states
// -----------------------------------------------------------------------------
package dp_pkg;

  localparam int LANES = 8;
  localparam int FP    = 16;

  localparam logic [FP-1:0] FP16_ZERO = 16'h0000;

  typedef logic [FP-1:0] fp16_t;

  typedef enum logic [0:0] {
    IDLE,
    FILL
  } state_t;

endpackage

// File: rtl/dp_result_fifo.sv
// -----------------------------------------------------------------------------
// dp_result_fifo
// Synchronous FIFO holding dot-product results until the consumer pops them.
// The head entry is read straight from the storage registers, so a pushed
// word is visible on o_data the cycle after the push.
//   i_clk    : clock
//   i_reset  : synchronous active-high reset (empties the FIFO)
//   i_push   : write i_data (dropped when full unless popping the same cycle)
//   i_data   : write data
//   i_pop    : remove head entry (ignored when empty)
//   o_data   : head entry
//   o_full   : DEPTH entries held
//   o_empty  : no entries held
// -----------------------------------------------------------------------------
module dp_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign o_full  = (count == COUNT_FULL);
  assign o_empty = (count == '0);

  // A full FIFO may still accept a push when the head leaves in the same
  // cycle: the vacated slot is exactly the one wr_ptr points at.
  assign push_ok = i_push && (!o_full || i_pop);
  assign pop_ok  = i_pop && !o_empty;

  assign o_data = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are meaningful, so stale contents are never observed.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_data;
  end

endmodule

// File: rtl/dot_product_feeder.sv
// -----------------------------------------------------------------------------
// dot_product_feeder
// Front end of the fp16 dot-product stack. Takes a vector length, then a
// stream of (a,b) element pairs, packs them into LANES-wide blocks (the tail
// block zero-padded), and drives the stack with registered a/b/first/last.
// Stack results are collected into a small FIFO. A vector is only accepted
// when a FIFO slot is guaranteed for its result, since the stack cannot stall.
//   i_clk, i_reset         : clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready: length command handshake, length on i_cmd_len
//   i_elem_valid/o_elem_ready: element pair handshake, pair on i_elem_a/b
//   o_a, o_b               : block to stack, lane j at [j*FP +: FP]
//   o_first, o_last        : block markers to stack
//   i_sum, i_sum_valid     : result from stack
//   o_res, o_res_valid, i_res_ready: result FIFO head and pop handshake
//   o_busy                 : vector in progress or results outstanding
//   o_err_overflow         : sticky, a result arrived with the FIFO full
// -----------------------------------------------------------------------------
module dot_product_feeder
  import dp_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int RES_DEPTH = 4,
  parameter int STACK_LAT = 10
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [LEN_W-1:0]    i_cmd_len,
  input  logic                i_elem_valid,
  output logic                o_elem_ready,
  input  logic [FP-1:0]       i_elem_a,
  input  logic [FP-1:0]       i_elem_b,
  output logic [LANES*FP-1:0] o_a,
  output logic [LANES*FP-1:0] o_b,
  output logic                o_first,
  output logic                o_last,
  input  logic [FP-1:0]       i_sum,
  input  logic                i_sum_valid,
  output logic [FP-1:0]       o_res,
  output logic                o_res_valid,
  input  logic                i_res_ready,
  output logic                o_busy,
  output logic                o_err_overflow
);

  localparam int LANE_W  = $clog2(LANES);
  localparam int OUT_W   = $clog2(RES_DEPTH + 1);
  localparam int DRAIN_W = $clog2(STACK_LAT + 1);

  localparam logic [LANE_W-1:0]  LAST_LANE  = LANE_W'(LANES - 1);
  localparam logic [OUT_W-1:0]   OUT_MAX    = OUT_W'(RES_DEPTH);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(STACK_LAT);

  state_t              state, state_next;
  logic [LANE_W-1:0]   lane, lane_next;
  logic [LEN_W-1:0]    remaining, remaining_next;
  logic                first_pend, first_pend_next;
  logic [LANES*FP-1:0] pack_a, pack_a_next;
  logic [LANES*FP-1:0] pack_b, pack_b_next;
  logic [LANES*FP-1:0] blk_a, blk_b;
  logic [LANES*FP-1:0] a_next, b_next;
  logic                first_next, last_next;

  logic [OUT_W-1:0]    outstanding;
  logic [DRAIN_W-1:0]  drain;

  logic                cmd_fire;
  logic                elem_fire;
  logic                res_push;
  logic                res_pop;
  logic                fifo_full;
  logic                fifo_empty;
  fp16_t               fifo_head;

  assign o_cmd_ready  = (state == IDLE) && (outstanding < OUT_MAX) && (drain == '0);
  assign o_elem_ready = (state == FILL);
  assign cmd_fire     = i_cmd_valid && o_cmd_ready;
  assign elem_fire    = i_elem_valid && o_elem_ready;

  assign o_busy = (state != IDLE) || (outstanding != '0);

  // ---------------------------------------------------------------------------
  // Packing FSM. Output block registers default to zero every cycle so the
  // always-accumulating stack sees 0*0 whenever no block is issued.
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next      = state;
    lane_next       = lane;
    remaining_next  = remaining;
    first_pend_next = first_pend;
    pack_a_next     = pack_a;
    pack_b_next     = pack_b;
    a_next          = '0;
    b_next          = '0;
    first_next      = 1'b0;
    last_next       = 1'b0;

    // Pack registers merged with the pair arriving this cycle; lanes not yet
    // written are still zero, which provides the tail padding.
    blk_a = pack_a;
    blk_b = pack_b;
    blk_a[lane*FP +: FP] = i_elem_a;
    blk_b[lane*FP +: FP] = i_elem_b;

    case (state)
      IDLE: begin
        if (cmd_fire) begin
          if (i_cmd_len == '0) begin
            // Empty vector: a single all-zero block still opens and closes
            // an accumulation so the stack produces a 0.0 result.
            first_next = 1'b1;
            last_next  = 1'b1;
          end else begin
            remaining_next  = i_cmd_len;
            lane_next       = '0;
            first_pend_next = 1'b1;
            state_next      = FILL;
          end
        end
      end

      FILL: begin
        if (elem_fire) begin
          remaining_next = remaining - LEN_W'(1);
          if ((lane == LAST_LANE) || (remaining == LEN_W'(1))) begin
            a_next          = blk_a;
            b_next          = blk_b;
            first_next      = first_pend;
            last_next       = (remaining == LEN_W'(1));
            first_pend_next = 1'b0;
            pack_a_next     = {LANES{FP16_ZERO}};
            pack_b_next     = {LANES{FP16_ZERO}};
            lane_next       = '0;
            if (remaining == LEN_W'(1)) state_next = IDLE;
          end else begin
            pack_a_next = blk_a;
            pack_b_next = blk_b;
            lane_next   = lane + LANE_W'(1);
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      lane       <= '0;
      remaining  <= '0;
      first_pend <= 1'b0;
      pack_a     <= '0;
      pack_b     <= '0;
      o_a        <= '0;
      o_b        <= '0;
      o_first    <= 1'b0;
      o_last     <= 1'b0;
    end else begin
      state      <= state_next;
      lane       <= lane_next;
      remaining  <= remaining_next;
      first_pend <= first_pend_next;
      pack_a     <= pack_a_next;
      pack_b     <= pack_b_next;
      o_a        <= a_next;
      o_b        <= b_next;
      o_first    <= first_next;
      o_last     <= last_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Result credits. outstanding counts vectors accepted whose result has not
  // yet been popped; holding it below RES_DEPTH guarantees a FIFO slot.
  // After reset the drain window discards results of vectors issued before
  // the reset, which are still travelling through the stack.
  // ---------------------------------------------------------------------------
  assign res_push    = i_sum_valid && (drain == '0);
  assign res_pop     = o_res_valid && i_res_ready;
  assign o_res_valid = !fifo_empty;
  assign o_res       = fifo_head;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      outstanding    <= '0;
      drain          <= DRAIN_INIT;
      o_err_overflow <= 1'b0;
    end else begin
      case ({cmd_fire, res_pop})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
      if (drain != '0) drain <= drain - DRAIN_W'(1);
      if (res_push && fifo_full && !res_pop) o_err_overflow <= 1'b1;
    end
  end

  dp_result_fifo #(
    .DEPTH (RES_DEPTH),
    .WIDTH (FP)
  ) u_result_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (res_push),
    .i_data  (i_sum),
    .i_pop   (res_pop),
    .o_data  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

endmodule
